// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_pkg
// Description : Shared definitions for the execute stage: ALU operation
//               codes, RegDst / MemtoReg encodings, divider state enum and
//               the operand forwarding helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_LUI  = 5'd11;
    localparam logic [4:0] ALU_DIVU = 5'd16;
    localparam logic [4:0] ALU_REMU = 5'd17;

    // Destination register select
    localparam logic [1:0] REGDST_RT   = 2'd0;
    localparam logic [1:0] REGDST_RD   = 2'd1;
    localparam logic [1:0] REGDST_RA   = 2'd2;
    localparam logic [1:0] REGDST_ZERO = 2'd3;

    // Write-back data select
    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_PC  = 2'd2;

    // Divider sequencer states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Operand bypass: the younger MEM result wins over WB; r0 is never bypassed.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  addr,
        input logic        mem_we,
        input logic [4:0]  mem_addr,
        input logic [31:0] mem_data,
        input logic        wb_we,
        input logic [4:0]  wb_addr,
        input logic [31:0] wb_data,
        input logic [31:0] reg_data
    );
        logic [31:0] v;
        v = reg_data;
        if (addr != 5'd0) begin
            if (mem_we && (mem_addr == addr))
                v = mem_data;
            else if (wb_we && (wb_addr == addr))
                v = wb_data;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_divu.sv
`default_nettype none
// ============================================================================
// Module      : ex_divu
// Description : 32-bit unsigned restoring divider, one quotient bit per cycle.
//               Present only when EX_STAGE_DIV_EN is defined.
//               Ports: clk, rst (sync, active-high), start (accepted in IDLE),
//               dividend, divisor -> busy, done, quotient, remainder.
//               Timing: start in IDLE, 32 BUSY cycles, one DONE cycle.
//               Divisor 0 naturally yields quotient all-ones and
//               remainder = dividend.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef EX_STAGE_DIV_EN
module ex_divu
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  r_state;
    logic [4:0]  r_count;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [32:0] w_trial;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    assign w_trial = {r_rem, r_quo[31]} - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
            r_count <= 5'd0;
            r_quo   <= 32'd0;
            r_rem   <= 32'd0;
            r_div   <= 32'd0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_quo   <= dividend;
                        r_rem   <= 32'd0;
                        r_div   <= divisor;
                        r_count <= 5'd0;
                        r_state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (!w_trial[32]) begin
                        r_rem <= w_trial[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[30:0], r_quo[31]};
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31)
                        r_state <= DIV_DONE;
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == DIV_BUSY);
    assign done      = (r_state == DIV_DONE);
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`endif
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Pipeline execute stage: operand forwarding, ALU, destination
//               select and the EX/MEM pipeline register. Optional multi-cycle
//               unsigned divide (DIVU/REMU) enabled by macro EX_STAGE_DIV_EN.
//               Inputs : ID/EX control and data, WB write port (forwarding).
//               Outputs: stall_div (hold PC, IF/ID, ID/EX), registered EX/MEM
//                        control, ALU result, store data, PC, write address.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WB_MemtoReg_ex,
    input  logic        WB_RegWrite_ex,
    input  logic        MEM_MemWrite_ex,
    input  logic        MEM_MemRead_ex,
    input  logic [4:0]  EX_ALUCode_ex,
    input  logic        EX_ALUSrcA_ex,
    input  logic        EX_ALUSrcB_ex,
    input  logic [1:0]  EX_RegDst_ex,
    input  logic [4:0]  RsAddr_ex,
    input  logic [4:0]  RtAddr_ex,
    input  logic [4:0]  RdAddr_ex,
    input  logic [31:0] PC_ex,
    input  logic [31:0] Imm_ex,
    input  logic [31:0] RsData_ex,
    input  logic [31:0] RtData_ex,
    input  logic        RegWrite_wb,
    input  logic [4:0]  RegWriteAddr_wb,
    input  logic [31:0] RegWriteData_wb,
    output logic        stall_div,
    output logic [1:0]  WB_MemtoReg_mem,
    output logic        WB_RegWrite_mem,
    output logic        MEM_MemWrite_mem,
    output logic        MEM_MemRead_mem,
    output logic [31:0] ALUResult_mem,
    output logic [31:0] MemWriteData_mem,
    output logic [31:0] PC_mem,
    output logic [4:0]  RegWriteAddr_mem
);

    logic [1:0]  r_memtoreg;
    logic        r_regwrite;
    logic        r_memwrite;
    logic        r_memread;
    logic [31:0] r_alu_result;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_pc;
    logic [4:0]  r_wr_addr;

    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_alu;
    logic [31:0] w_result;
    logic [4:0]  w_dst;
    logic        w_stall;

    // ------------------------------------------------------------------
    // Forwarding and operand select
    // ------------------------------------------------------------------
    assign w_fwd_rs = fwd_sel(RsAddr_ex, r_regwrite, r_wr_addr, r_alu_result,
                              RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, RsData_ex);
    assign w_fwd_rt = fwd_sel(RtAddr_ex, r_regwrite, r_wr_addr, r_alu_result,
                              RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb, RtData_ex);

    // Source A immediate is the shamt field for constant shifts.
    assign w_op_a = EX_ALUSrcA_ex ? {27'd0, Imm_ex[10:6]} : w_fwd_rs;
    assign w_op_b = EX_ALUSrcB_ex ? Imm_ex : w_fwd_rt;

    // ------------------------------------------------------------------
    // ALU (divide codes fall to default; their result comes from ex_divu)
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = 32'd0;
        case (EX_ALUCode_ex)
            ALU_ADD:  w_alu = w_op_a + w_op_b;
            ALU_SUB:  w_alu = w_op_a - w_op_b;
            ALU_AND:  w_alu = w_op_a & w_op_b;
            ALU_OR:   w_alu = w_op_a | w_op_b;
            ALU_XOR:  w_alu = w_op_a ^ w_op_b;
            ALU_NOR:  w_alu = ~(w_op_a | w_op_b);
            ALU_SLT:  w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLTU: w_alu = {31'd0, w_op_a < w_op_b};
            ALU_SLL:  w_alu = w_op_b << w_op_a[4:0];
            ALU_SRL:  w_alu = w_op_b >> w_op_a[4:0];
            ALU_SRA:  w_alu = $signed(w_op_b) >>> w_op_a[4:0];
            ALU_LUI:  w_alu = w_op_b << 16;
            default:  w_alu = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Destination register select
    // ------------------------------------------------------------------
    always_comb begin
        w_dst = RtAddr_ex;
        case (EX_RegDst_ex)
            REGDST_RT:   w_dst = RtAddr_ex;
            REGDST_RD:   w_dst = RdAddr_ex;
            REGDST_RA:   w_dst = 5'd31;
            REGDST_ZERO: w_dst = 5'd0;
            default:     w_dst = RtAddr_ex;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional divider
    // ------------------------------------------------------------------
`ifdef EX_STAGE_DIV_EN
    logic        w_is_div;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_is_div = (EX_ALUCode_ex == ALU_DIVU) || (EX_ALUCode_ex == ALU_REMU);

    ex_divu u_divu (
        .clk       (clk),
        .rst       (rst),
        .start     (w_is_div),
        .dividend  (w_fwd_rs),
        .divisor   (w_fwd_rt),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    // Stall covers the accepting IDLE cycle and all BUSY cycles. In DONE the
    // upstream stages still hold the divide op, so start is not re-sampled.
    assign w_stall  = !rst && !w_div_done && (w_is_div || w_div_busy);
    assign w_result = w_div_done ? ((EX_ALUCode_ex == ALU_REMU) ? w_rem : w_quo)
                                 : w_alu;
`else
    assign w_stall  = 1'b0;
    assign w_result = w_alu;
`endif

    assign stall_div = w_stall;

    // ------------------------------------------------------------------
    // EX/MEM pipeline register; a stalled cycle inserts a control bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_memtoreg   <= 2'd0;
            r_regwrite   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_alu_result <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_pc         <= 32'd0;
            r_wr_addr    <= 5'd0;
        end else begin
            if (w_stall) begin
                r_memtoreg <= 2'd0;
                r_regwrite <= 1'b0;
                r_memwrite <= 1'b0;
                r_memread  <= 1'b0;
            end else begin
                r_memtoreg <= WB_MemtoReg_ex;
                r_regwrite <= WB_RegWrite_ex;
                r_memwrite <= MEM_MemWrite_ex;
                r_memread  <= MEM_MemRead_ex;
            end
            r_alu_result <= w_result;
            r_mem_wdata  <= w_fwd_rt;
            r_pc         <= PC_ex;
            r_wr_addr    <= w_dst;
        end
    end

    assign WB_MemtoReg_mem  = r_memtoreg;
    assign WB_RegWrite_mem  = r_regwrite;
    assign MEM_MemWrite_mem = r_memwrite;
    assign MEM_MemRead_mem  = r_memread;
    assign ALUResult_mem    = r_alu_result;
    assign MemWriteData_mem = r_mem_wdata;
    assign PC_mem           = r_pc;
    assign RegWriteAddr_mem = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage. Table of ALU vectors plus
//               hand sequences for forwarding, reset and (when EX_STAGE_DIV_EN
//               is defined) the multi-cycle divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  WB_MemtoReg_ex;
    logic        WB_RegWrite_ex;
    logic        MEM_MemWrite_ex;
    logic        MEM_MemRead_ex;
    logic [4:0]  EX_ALUCode_ex;
    logic        EX_ALUSrcA_ex;
    logic        EX_ALUSrcB_ex;
    logic [1:0]  EX_RegDst_ex;
    logic [4:0]  RsAddr_ex;
    logic [4:0]  RtAddr_ex;
    logic [4:0]  RdAddr_ex;
    logic [31:0] PC_ex;
    logic [31:0] Imm_ex;
    logic [31:0] RsData_ex;
    logic [31:0] RtData_ex;
    logic        RegWrite_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic [31:0] RegWriteData_wb;
    logic        stall_div;
    logic [1:0]  WB_MemtoReg_mem;
    logic        WB_RegWrite_mem;
    logic        MEM_MemWrite_mem;
    logic        MEM_MemRead_mem;
    logic [31:0] ALUResult_mem;
    logic [31:0] MemWriteData_mem;
    logic [31:0] PC_mem;
    logic [4:0]  RegWriteAddr_mem;

    logic [4:0]  ctl_out;
    assign ctl_out = {WB_MemtoReg_mem, WB_RegWrite_mem, MEM_MemWrite_mem, MEM_MemRead_mem};

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .WB_MemtoReg_ex   (WB_MemtoReg_ex),
        .WB_RegWrite_ex   (WB_RegWrite_ex),
        .MEM_MemWrite_ex  (MEM_MemWrite_ex),
        .MEM_MemRead_ex   (MEM_MemRead_ex),
        .EX_ALUCode_ex    (EX_ALUCode_ex),
        .EX_ALUSrcA_ex    (EX_ALUSrcA_ex),
        .EX_ALUSrcB_ex    (EX_ALUSrcB_ex),
        .EX_RegDst_ex     (EX_RegDst_ex),
        .RsAddr_ex        (RsAddr_ex),
        .RtAddr_ex        (RtAddr_ex),
        .RdAddr_ex        (RdAddr_ex),
        .PC_ex            (PC_ex),
        .Imm_ex           (Imm_ex),
        .RsData_ex        (RsData_ex),
        .RtData_ex        (RtData_ex),
        .RegWrite_wb      (RegWrite_wb),
        .RegWriteAddr_wb  (RegWriteAddr_wb),
        .RegWriteData_wb  (RegWriteData_wb),
        .stall_div        (stall_div),
        .WB_MemtoReg_mem  (WB_MemtoReg_mem),
        .WB_RegWrite_mem  (WB_RegWrite_mem),
        .MEM_MemWrite_mem (MEM_MemWrite_mem),
        .MEM_MemRead_mem  (MEM_MemRead_mem),
        .ALUResult_mem    (ALUResult_mem),
        .MemWriteData_mem (MemWriteData_mem),
        .PC_mem           (PC_mem),
        .RegWriteAddr_mem (RegWriteAddr_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  code;
        logic        sa;
        logic        sb;
        logic [1:0]  dsel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  ctl;   // {MemtoReg[1:0], RegWrite, MemWrite, MemRead}
        logic [31:0] exp_alu;
        logic [4:0]  exp_dst;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] code, input logic sa, input logic sb,
                                input logic [1:0] dsel, input logic [31:0] rsd,
                                input logic [31:0] rtd, input logic [31:0] imm,
                                input logic [4:0] ctl, input logic [31:0] exp_alu,
                                input logic [4:0] exp_dst);
        vec_t x;
        x.code = code; x.sa = sa; x.sb = sb; x.dsel = dsel;
        x.rs = 5'd1; x.rt = 5'd2; x.rd = 5'd3;
        x.rsd = rsd; x.rtd = rtd; x.imm = imm; x.pc = 32'h0000_1000;
        x.ctl = ctl; x.exp_alu = exp_alu; x.exp_dst = exp_dst;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        EX_ALUCode_ex   = x.code;
        EX_ALUSrcA_ex   = x.sa;
        EX_ALUSrcB_ex   = x.sb;
        EX_RegDst_ex    = x.dsel;
        RsAddr_ex       = x.rs;
        RtAddr_ex       = x.rt;
        RdAddr_ex       = x.rd;
        RsData_ex       = x.rsd;
        RtData_ex       = x.rtd;
        Imm_ex          = x.imm;
        PC_ex           = x.pc;
        WB_MemtoReg_ex  = x.ctl[4:3];
        WB_RegWrite_ex  = x.ctl[2];
        MEM_MemWrite_ex = x.ctl[1];
        MEM_MemRead_ex  = x.ctl[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " ctl"},   {27'd0, ctl_out}, 32'd0);
        chk({tag, " alu"},   ALUResult_mem, 32'd0);
        chk({tag, " mwd"},   MemWriteData_mem, 32'd0);
        chk({tag, " pc"},    PC_mem, 32'd0);
        chk({tag, " waddr"}, {27'd0, RegWriteAddr_mem}, 32'd0);
        chk({tag, " stall"}, {31'd0, stall_div}, 32'd0);
    endtask

`ifdef EX_STAGE_DIV_EN
    task automatic run_div(input string nm, input logic [4:0] code, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        vec_t x;
        int   n;
        int   bad;
        x = mk(code, 1'b0, 1'b0, 2'd1, a, b, 32'd0, 5'b00100, exp, 5'd12);
        x.rs = 5'd13; x.rt = 5'd14; x.rd = 5'd12;
        drive(x);
        #1;
        n   = 0;
        bad = 0;
        while (stall_div && n < 40) begin
            step();
            n++;
            if (ctl_out !== 5'd0) bad++;
        end
        chk({nm, " stall cycles"}, n, 33);
        chk({nm, " bubbles"}, bad, 0);
        step();
        chk({nm, " result"}, ALUResult_mem, exp);
        chk({nm, " waddr"}, {27'd0, RegWriteAddr_mem}, 32'd12);
        chk({nm, " ctl"}, {27'd0, ctl_out}, 32'd4);
        drive(mk(5'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'b00000, 32'd0, 5'd2));
    endtask
`endif

    vec_t v[14];

    initial begin
        vec_t x;

        // ALU vectors; RegWrite kept 0 so no forwarding between rows
        v[0]  = mk(5'd0,  0, 0, 2'd0, 32'd7,        32'd5,        32'd0,        5'b01000, 32'd12,       5'd2);
        v[1]  = mk(5'd1,  0, 0, 2'd1, 32'd5,        32'd7,        32'd0,        5'b00010, 32'hFFFF_FFFE, 5'd3);
        v[2]  = mk(5'd2,  0, 0, 2'd1, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0,       5'b00001, 32'h00F0_F000, 5'd3);
        v[3]  = mk(5'd3,  0, 0, 2'd1, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0,       5'b10000, 32'hFFF0_FFF0, 5'd3);
        v[4]  = mk(5'd4,  0, 0, 2'd1, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0,       5'b01011, 32'hFF00_0FF0, 5'd3);
        v[5]  = mk(5'd5,  0, 0, 2'd1, 32'h1234_5678, 32'd0,        32'd0,        5'b00000, 32'hEDCB_A987, 5'd3);
        v[6]  = mk(5'd6,  0, 0, 2'd1, 32'hFFFF_FFFF, 32'd1,        32'd0,        5'b00000, 32'd1,        5'd3);
        v[7]  = mk(5'd7,  0, 0, 2'd1, 32'hFFFF_FFFF, 32'd1,        32'd0,        5'b00000, 32'd0,        5'd3);
        v[8]  = mk(5'd8,  1, 0, 2'd1, 32'hFFFF_FFFF, 32'd3,        32'h0000_0100, 5'b00000, 32'h30,       5'd3);
        v[9]  = mk(5'd9,  0, 0, 2'd1, 32'd8,        32'h8000_0000, 32'd0,        5'b00000, 32'h0080_0000, 5'd3);
        v[10] = mk(5'd10, 0, 0, 2'd1, 32'd4,        32'h8000_0000, 32'd0,        5'b00000, 32'hF800_0000, 5'd3);
        v[11] = mk(5'd11, 0, 1, 2'd2, 32'd0,        32'h0000_AAAA, 32'h0000_1234, 5'b00000, 32'h1234_0000, 5'd31);
        v[12] = mk(5'd12, 0, 0, 2'd3, 32'd9,        32'd9,        32'd0,        5'b00000, 32'd0,        5'd0);
        v[13] = mk(5'd0,  0, 1, 2'd0, 32'd1,        32'd0,        32'hFFFF_FFFF, 5'b00000, 32'd0,        5'd2);
        for (int i = 0; i < 14; i++) v[i].pc = 32'h0000_1000 + 32'(i * 4);

        // Reset
        rst = 1'b1;
        RegWrite_wb = 1'b0; RegWriteAddr_wb = 5'd0; RegWriteData_wb = 32'd0;
        drive(mk(5'd0, 0, 0, 2'd1, 32'h55, 32'h66, 32'h77, 5'b11111, 32'd0, 5'd0));
        step();
        step();
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Table-driven ALU checks
        for (int i = 0; i < 14; i++) begin
            drive(v[i]);
            step();
            chk($sformatf("vec%0d alu", i),   ALUResult_mem, v[i].exp_alu);
            chk($sformatf("vec%0d waddr", i), {27'd0, RegWriteAddr_mem}, {27'd0, v[i].exp_dst});
            chk($sformatf("vec%0d mwd", i),   MemWriteData_mem, v[i].rtd);
            chk($sformatf("vec%0d pc", i),    PC_mem, v[i].pc);
            chk($sformatf("vec%0d ctl", i),   {27'd0, ctl_out}, {27'd0, v[i].ctl});
            chk($sformatf("vec%0d stall", i), {31'd0, stall_div}, 32'd0);
        end

        // ADD overflow wraps, result to Rd
        x = mk(5'd0, 0, 0, 2'd1, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'b00100, 32'h8000_0000, 5'd9);
        x.rs = 5'd5; x.rt = 5'd6; x.rd = 5'd9;
        drive(x);
        step();
        chk("add wrap alu", ALUResult_mem, 32'h8000_0000);
        chk("add wrap waddr", {27'd0, RegWriteAddr_mem}, 32'd9);
        chk("add wrap regwrite", {31'd0, WB_RegWrite_mem}, 32'd1);

        // ADD r3 = 4 + 6
        x = mk(5'd0, 0, 0, 2'd1, 32'd4, 32'd6, 32'd0, 5'b00100, 32'd10, 5'd3);
        x.rs = 5'd1; x.rt = 5'd2; x.rd = 5'd3;
        drive(x);
        step();
        chk("add r3", ALUResult_mem, 32'd10);

        // SUB r4 = r3 - r3; MEM bypass beats a conflicting WB value
        x = mk(5'd1, 0, 0, 2'd1, 32'd77, 32'd77, 32'd0, 5'b00100, 32'd0, 5'd4);
        x.rs = 5'd3; x.rt = 5'd3; x.rd = 5'd4;
        RegWrite_wb = 1'b1; RegWriteAddr_wb = 5'd3; RegWriteData_wb = 32'd55;
        drive(x);
        step();
        chk("mem fwd sub", ALUResult_mem, 32'd0);
        chk("mem fwd store data", MemWriteData_mem, 32'd10);

        // MEM now holds r4; r3 comes from WB only; Rt=r0 is never bypassed
        x = mk(5'd0, 0, 0, 2'd1, 32'd77, 32'd1, 32'd0, 5'b00100, 32'd56, 5'd5);
        x.rs = 5'd3; x.rt = 5'd0; x.rd = 5'd5;
        drive(x);
        step();
        chk("wb fwd add", ALUResult_mem, 32'd56);

        // Write to r0 through MEM and WB; next op must read the register file
        x = mk(5'd0, 0, 0, 2'd3, 32'd100, 32'd200, 32'd0, 5'b00100, 32'd300, 5'd0);
        x.rs = 5'd0; x.rt = 5'd0; x.rd = 5'd7;
        RegWrite_wb = 1'b1; RegWriteAddr_wb = 5'd0; RegWriteData_wb = 32'd999;
        drive(x);
        step();
        chk("r0 producer", ALUResult_mem, 32'd300);
        x = mk(5'd0, 0, 0, 2'd1, 32'd11, 32'd22, 32'd0, 5'b00100, 32'd33, 5'd7);
        x.rs = 5'd0; x.rt = 5'd0; x.rd = 5'd7;
        drive(x);
        step();
        chk("r0 no fwd", ALUResult_mem, 32'd33);
        RegWrite_wb = 1'b0; RegWriteAddr_wb = 5'd0; RegWriteData_wb = 32'd0;

`ifdef EX_STAGE_DIV_EN
        run_div("divu 100/7", 5'd16, 32'd100, 32'd7, 32'd14);
        run_div("remu 100/7", 5'd17, 32'd100, 32'd7, 32'd2);
        run_div("divu 5/0",   5'd16, 32'd5,   32'd0, 32'hFFFF_FFFF);
        run_div("remu 5/0",   5'd17, 32'd5,   32'd0, 32'd5);

        // Abort a divide with reset at BUSY count 10
        x = mk(5'd16, 0, 0, 2'd1, 32'd100, 32'd7, 32'd0, 5'b00100, 32'd14, 5'd12);
        x.rs = 5'd13; x.rt = 5'd14; x.rd = 5'd12;
        drive(x);
        for (int i = 0; i < 11; i++) step();
        chk("abort busy stall", {31'd0, stall_div}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort stall during rst", {31'd0, stall_div}, 32'd0);
        step();
        chk_zero_outputs("abort");
        rst = 1'b0;
        x = mk(5'd0, 0, 0, 2'd1, 32'd2, 32'd3, 32'd0, 5'b00100, 32'd5, 5'd7);
        x.rs = 5'd1; x.rt = 5'd2; x.rd = 5'd7;
        drive(x);
        #1;
        chk("post abort stall", {31'd0, stall_div}, 32'd0);
        step();
        chk("post abort add", ALUResult_mem, 32'd5);
        chk("post abort waddr", {27'd0, RegWriteAddr_mem}, 32'd7);
        step();
        chk("no late div result", ALUResult_mem, 32'd5);
`else
        // Divider absent: divide codes are single-cycle and yield 0
        x = mk(5'd16, 0, 0, 2'd1, 32'd100, 32'd7, 32'd0, 5'b00100, 32'd0, 5'd12);
        x.rs = 5'd13; x.rt = 5'd14; x.rd = 5'd12;
        drive(x);
        #1;
        chk("nodiv divu stall", {31'd0, stall_div}, 32'd0);
        step();
        chk("nodiv divu result", ALUResult_mem, 32'd0);
        chk("nodiv divu regwrite", {31'd0, WB_RegWrite_mem}, 32'd1);
        chk("nodiv divu stall after", {31'd0, stall_div}, 32'd0);
        x.code = 5'd17;
        drive(x);
        step();
        chk("nodiv remu result", ALUResult_mem, 32'd0);
        chk("nodiv remu stall", {31'd0, stall_div}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 WB_MemtoReg_ex[1:0], WB_RegWrite_ex, MEM_MemWrite_ex, MEM_MemRead_ex  in  control from ID/EX register.
REQ-004 EX_ALUCode_ex  in  5  ALU operation; EX_ALUSrcA_ex, EX_ALUSrcB_ex  in  1; EX_RegDst_ex  in  2.
REQ-005 RsAddr_ex, RtAddr_ex, RdAddr_ex  in  5; PC_ex, Imm_ex, RsData_ex, RtData_ex  in  32.
REQ-006 RegWrite_wb  in  1; RegWriteAddr_wb  in  5; RegWriteData_wb  in  32: WB-stage write port, used for forwarding.
REQ-007 stall_div  out  1  high = PC, IF/ID and ID/EX hold their contents this cycle.
REQ-008 WB_MemtoReg_mem[1:0], WB_RegWrite_mem, MEM_MemWrite_mem, MEM_MemRead_mem  out  registered control.
REQ-009 ALUResult_mem, MemWriteData_mem, PC_mem  out  32; RegWriteAddr_mem  out  5; all registered.

Function
REQ-010 Forward A/B: the MEM source (WB_RegWrite_mem, RegWriteAddr_mem==addr, ALUResult_mem) has priority over the WB source; otherwise use RsData_ex/RtData_ex; address 0 is never forwarded.
REQ-011 Operand A = ALUSrcA ? {27'b0, Imm_ex[10:6]} : fwdRs; operand B = ALUSrcB ? Imm_ex : fwdRt.
REQ-012 ALUCode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA (shift B by A[4:0]), 11 LUI (B<<16), 16 DIVU, 17 REMU; other codes yield result 0.
REQ-013 ADD/SUB wrap modulo 2^32 with no overflow flag.
REQ-014 Destination: RegDst 0 -> RtAddr_ex, 1 -> RdAddr_ex, 2 -> 31, 3 -> 0.
REQ-015 Non-divide ops: EX/MEM registers load every cycle with 1-cycle latency; MemWriteData_mem = fwdRt.
REQ-016 Divider FSM states: IDLE, BUSY, DONE.
REQ-017 IDLE with code 16/17: latch fwd operands, go to BUSY, count=0; stall_div=1 in this cycle.
REQ-018 BUSY: one restoring-division step per cycle; count 0..31; after step 31 go to DONE; stall_div=1.
REQ-019 DONE: stall_div=0; EX/MEM loads the quotient (16) or remainder (17) with the held control; next state IDLE.
REQ-020 A divide occupies 34 cycles: 33 stalled plus the DONE cycle.
REQ-021 While stall_div=1, EX/MEM loads a bubble: all four control outputs=0; the data fields are don't-care.
REQ-022 DONE completes the held op, not a new one; the op after the divide is accepted in the following IDLE cycle.
REQ-023 Divisor 0: quotient 0xFFFFFFFF, remainder = dividend; latency is unchanged.

Reset
REQ-024 While rst=1: all outputs 0, FSM to IDLE, count 0, stall_div 0.
REQ-025 rst asserted mid-divide aborts the operation; no result is ever written.

Configuration
REQ-026 Macro EX_STAGE_DIV_EN defined: divider and FSM present as specified above.
REQ-027 Macro undefined: no divider logic; codes 16/17 yield result 0 with 1-cycle latency; stall_div is tied to 0.

Structure
REQ-028 A shared package holds the ALUCode constants, the RegDst/MemtoReg encodings and the divider state enum.
REQ-029 The divider is sub-module ex_divu (start, dividend, divisor -> busy, done, quotient, remainder).
REQ-030 Forwarding, ALU and the EX/MEM register reside in ex_stage.

Verification
REQ-031 ADD with Rs=5 (0x7FFFFFFF), Rt=6 (1), RegDst=1, Rd=9: next cycle ALUResult_mem=0x80000000, RegWriteAddr_mem=9.
REQ-032 Back-to-back: ADD r3 writes 10, then SUB r4=r3-r3 with stale RsData_ex=77: ALUResult_mem=0 via MEM forward; the WB forward is used only when MEM does not match.
REQ-033 Forwarding to r0 with RegWrite_mem=1 and RegWriteAddr_mem=0: operand equals RsData_ex, not the forwarded value.
REQ-034 DIVU 100/7: stall_div high for 33 cycles, bubbles on the control outputs, then ALUResult_mem=14; REMU gives 2; DIVU 5/0 gives 0xFFFFFFFF.
REQ-035 rst asserted at BUSY count 10: all outputs 0 next cycle, stall_div=0, and the next ADD completes in 1 cycle.
REQ-036 Build without EX_STAGE_DIV_EN: DIVU gives result 0 and stall_div never rises.
